// File: rtl/topk_accum_8.sv
// Running top-8 accumulator: bitonic-merges successive descending-sorted batches
// of one frame into a held top-8 and delivers it on a valid/ready port.
module topk_accum_8 #(
   parameter int DATAWIDTH  = 8,
   parameter int DATALENGTH = 8,
   parameter int SIGNED     = 0,
   parameter int CNTWIDTH   = 16
) (
   input  logic                                 clk_i,
   input  logic                                 rstn_i,
   input  logic                                 in_valid_i,
   output logic                                 in_ready_o,
   input  logic                                 in_last_i,
   input  logic [DATALENGTH-1:0][DATAWIDTH-1:0] x_i,
   output logic                                 out_valid_o,
   input  logic                                 out_ready_i,
   output logic [DATALENGTH-1:0][DATAWIDTH-1:0] y_o,
   output logic [CNTWIDTH-1:0]                  batch_cnt_o
);

   typedef logic [DATAWIDTH-1:0]                  elem_t;
   typedef logic [DATALENGTH-1:0][DATAWIDTH-1:0]  vec_t;
   typedef enum logic [1:0] {S_EMPTY, S_HOLD, S_MERGE, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   vec_t                r_held;
   vec_t                r_m;
   vec_t                r_y;
   logic [CNTWIDTH-1:0] r_cnt;
   logic [CNTWIDTH-1:0] r_ycnt;
   logic                r_last;

   logic                w_in_ready;
   logic                w_accept;
   vec_t                w_pairmax;
   vec_t                w_s1;
   vec_t                w_s2;
   vec_t                w_merged;

   function automatic logic gt(input elem_t a, input elem_t b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      return a > b;
   endfunction

   // One half-cleaner: each pair (i, i^stride) is ordered larger-first.
   function automatic vec_t half_clean(input vec_t v, input int stride);
      vec_t r;
      r = v;
      for (int i = 0; i < DATALENGTH; i++) begin
         if ((i & stride) == 0 && gt(v[i ^ stride], v[i])) begin
            r[i]          = v[i ^ stride];
            r[i ^ stride] = v[i];
         end
      end
      return r;
   endfunction

   assign w_in_ready  = (r_state == S_EMPTY) || (r_state == S_HOLD);
   assign in_ready_o  = rstn_i & w_in_ready;
   assign w_accept    = in_valid_i & in_ready_o;
   assign out_valid_o = (r_state == S_DONE);
   assign y_o         = r_y;
   assign batch_cnt_o = r_ycnt;

   // Held is descending, reversed batch is ascending: lane-wise max is bitonic
   // and holds the top 8 of the 16 candidates.
   always_comb begin
      w_pairmax = r_held;
      for (int i = 0; i < DATALENGTH; i++) begin
         if (gt(x_i[DATALENGTH-1-i], r_held[i])) w_pairmax[i] = x_i[DATALENGTH-1-i];
      end
   end

   assign w_s1     = half_clean(r_m,  DATALENGTH / 2);
   assign w_s2     = half_clean(w_s1, DATALENGTH / 4);
   assign w_merged = half_clean(w_s2, DATALENGTH / 8);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= S_EMPTY;
      else         r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first so every path assigns w_state_nxt and no latch is inferred.
      w_state_nxt = r_state;
      unique case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = in_last_i ? S_DONE : S_HOLD;
         S_HOLD:  if (w_accept) w_state_nxt = S_MERGE;
         S_MERGE: w_state_nxt = r_last ? S_DONE : S_HOLD;
         S_DONE:  if (out_ready_i) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // NOTE: the held/merge vectors are plain registers, so they take the async
   // reset along with everything else; a reset must discard all frame data.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_held <= '0;
         r_m    <= '0;
         r_y    <= '0;
         r_cnt  <= '0;
         r_ycnt <= '0;
         r_last <= 1'b0;
      end else begin
         unique case (r_state)
            S_EMPTY: if (w_accept) begin
               r_held <= x_i;
               r_cnt  <= CNTWIDTH'(1);
               if (in_last_i) begin
                  r_y    <= x_i;
                  r_ycnt <= CNTWIDTH'(1);
               end
            end
            S_HOLD: if (w_accept) begin
               r_m    <= w_pairmax;
               r_last <= in_last_i;
               if (r_cnt != '1) r_cnt <= r_cnt + CNTWIDTH'(1);
            end
            S_MERGE: begin
               r_held <= w_merged;
               if (r_last) begin
                  r_y    <= w_merged;
                  r_ycnt <= r_cnt;
               end
            end
            S_DONE: if (out_ready_i) begin
               r_held <= '0;
               r_cnt  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_topk_accum_8.sv
// Directed bench for topk_accum_8: an unsigned/16-bit-count instance and a
// signed/2-bit-count instance share one stimulus stream.
module tb_topk_accum_8;

   typedef logic [7:0][7:0] vec_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_last;
   vec_t        x;
   logic        out_ready;
   logic        rdy_u, rdy_s, ov_u, ov_s;
   vec_t        y_u, y_s;
   logic [15:0] cnt_u;
   logic [1:0]  cnt_s;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   topk_accum_8 u_uns (
      .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy_u),
      .in_last_i(in_last), .x_i(x), .out_valid_o(ov_u), .out_ready_i(out_ready),
      .y_o(y_u), .batch_cnt_o(cnt_u)
   );

   topk_accum_8 #(.SIGNED(1), .CNTWIDTH(2)) u_sgn (
      .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid), .in_ready_o(rdy_s),
      .in_last_i(in_last), .x_i(x), .out_valid_o(ov_s), .out_ready_i(out_ready),
      .y_o(y_s), .batch_cnt_o(cnt_s)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Element 0 is the largest lane.
   function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
      vec_t v;
      v[0] = 8'(a0); v[1] = 8'(a1); v[2] = 8'(a2); v[3] = 8'(a3);
      v[4] = 8'(a4); v[5] = 8'(a5); v[6] = 8'(a6); v[7] = 8'(a7);
      return v;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic send(input vec_t v, input logic last);
      int n;
      n = 0;
      in_valid = 1'b1;
      x        = v;
      in_last  = last;
      while (!rdy_u && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 64'(rdy_u), 64'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!ov_u && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("out_valid", 64'(ov_u), 64'(1));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t exp_y;
      rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; x = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_y",     y_u, 64'(0));
      check("rst_cnt",   64'(cnt_u), 64'(0));
      check("rst_valid", 64'(ov_u), 64'(0));
      check("rst_ready", 64'(rdy_u), 64'(0));
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(rdy_u), 64'(1));

      // Single-batch frame
      exp_y = mk(9, 7, 5, 4, 3, 2, 1, 0);
      send(exp_y, 1'b1);
      @(negedge clk);
      check("single_valid", 64'(ov_u), 64'(1));
      check("single_y_u",   y_u, exp_y);
      check("single_y_s",   y_s, exp_y);
      check("single_cnt_u", 64'(cnt_u), 64'(1));
      check("single_cnt_s", 64'(cnt_s), 64'(1));
      release_out();
      check("single_rel_ready", 64'(rdy_u), 64'(1));
      check("single_rel_valid", 64'(ov_u), 64'(0));
      check("single_keep_y",    y_u, exp_y);

      // Two-batch merge with backpressure
      send(mk(20, 15, 10, 5, 4, 3, 2, 1), 1'b0);
      send(mk(18, 12, 11, 6, 0, 0, 0, 0), 1'b1);
      check("merge_ready_low", 64'(rdy_u), 64'(0));
      wait_valid();
      exp_y = mk(20, 18, 15, 12, 11, 10, 6, 5);
      check("two_y_u",   y_u, exp_y);
      check("two_y_s",   y_s, exp_y);
      check("two_cnt_u", 64'(cnt_u), 64'(2));
      check("two_cnt_s", 64'(cnt_s), 64'(2));
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_last  = 1'b1;
         x        = mk(127, 126, 125, 124, 123, 122, 121, 120);
         @(negedge clk);
         check("bp_y",     y_u, exp_y);
         check("bp_valid", 64'(ov_u), 64'(1));
         check("bp_ready", 64'(rdy_u), 64'(0));
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      release_out();
      check("bp_rel_ready", 64'(rdy_u), 64'(1));
      check("bp_rel_valid", 64'(ov_u), 64'(0));
      check("bp_keep_cnt",  64'(cnt_u), 64'(2));

      // Unsigned values above 127 (unsigned instance only)
      send(mk(250, 200, 150, 128, 127, 5, 3, 1), 1'b0);
      send(mk(255, 129, 2, 2, 2, 2, 2, 0), 1'b1);
      wait_valid();
      check("uns_y", y_u, mk(255, 250, 200, 150, 129, 128, 127, 5));
      check("uns_cnt", 64'(cnt_u), 64'(2));
      release_out();

      // Signed mode (signed instance only)
      send(mk(3, 1, 0, -1, -2, -3, -4, -5), 1'b0);
      send(mk(2, -6, -7, -8, -9, -10, -11, -12), 1'b1);
      wait_valid();
      check("sgn_y", y_s, mk(3, 2, 1, 0, -1, -2, -3, -4));
      check("sgn_valid", 64'(ov_s), 64'(1));
      release_out();

      // Five batches: 2-bit count saturates at 3
      send(mk(100, 90, 80, 70, 60, 50, 40, 30), 1'b0);
      send(mk(95, 85, 75, 65, 55, 45, 35, 25), 1'b0);
      send(mk(99, 98, 1, 1, 1, 1, 1, 1), 1'b0);
      send(mk(120, 2, 2, 2, 2, 2, 2, 2), 1'b0);
      send(mk(97, 96, 94, 0, 0, 0, 0, 0), 1'b1);
      wait_valid();
      exp_y = mk(120, 100, 99, 98, 97, 96, 95, 94);
      check("sat_y_u",   y_u, exp_y);
      check("sat_y_s",   y_s, exp_y);
      check("sat_cnt_u", 64'(cnt_u), 64'(5));
      check("sat_cnt_s", 64'(cnt_s), 64'(3));
      release_out();

      // Reset while in MERGE
      send(mk(50, 40, 30, 20, 10, 9, 8, 7), 1'b0);
      send(mk(60, 55, 45, 35, 25, 15, 5, 1), 1'b0);
      check("pre_rst_ready", 64'(rdy_u), 64'(0));
      rstn = 1'b0;
      #1;
      check("mid_rst_y",     y_u, 64'(0));
      check("mid_rst_cnt",   64'(cnt_u), 64'(0));
      check("mid_rst_valid", 64'(ov_u), 64'(0));
      check("mid_rst_ready", 64'(rdy_u), 64'(0));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      exp_y = mk(1, 1, 1, 1, 1, 1, 1, 1);
      send(exp_y, 1'b1);
      @(negedge clk);
      check("after_rst_valid", 64'(ov_u), 64'(1));
      check("after_rst_y",     y_u, exp_y);
      check("after_rst_cnt_u", 64'(cnt_u), 64'(1));
      check("after_rst_cnt_s", 64'(cnt_s), 64'(1));
      release_out();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
